// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
package pipe_hazard_ctrl_pkg;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_NUM_REGS   = 8;
    localparam int DEF_CNT_W      = 32;

    // Architectural register number at the default register count.
    typedef logic [$clog2(DEF_NUM_REGS)-1:0] lc3b_reg;

    // How the pipeline registers move on the coming edge.
    typedef enum logic [1:0] {
        ADV_NORMAL,   // everything advances
        ADV_BUBBLE,   // IF/ID holds, NOP into ID/EX
        ADV_FLUSH,    // IF/ID and ID/EX squashed
        ADV_HOLD      // global stall, nothing moves
    } adv_mode_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int CNT_W      = DEF_CNT_W
) ();

    localparam int NP    = NUM_STAGES - 1;
    localparam int REG_W = $clog2(NUM_REGS);

    logic             stall_if;
    logic             stall_mem;
    logic             if_valid;
    logic             id_uses_sr1;
    logic             id_uses_sr2;
    logic [REG_W-1:0] id_sr1;
    logic [REG_W-1:0] id_sr2;
    logic             id_writes;
    logic [REG_W-1:0] id_dest;
    logic             ex_writes;
    logic [REG_W-1:0] ex_dest;
    logic             wb_writes;
    logic [REG_W-1:0] wb_dest;
    logic             br_taken;
    logic [NP-1:0]    load_en;
    logic [NP-1:0]    valid;
    logic             bubble;
    logic             flush;
    logic [CNT_W-1:0] stall_cycles;

    // Controller side.
    modport slave (
        input  stall_if, stall_mem, if_valid,
        input  id_uses_sr1, id_uses_sr2, id_sr1, id_sr2, id_writes, id_dest,
        input  ex_writes, ex_dest, wb_writes, wb_dest, br_taken,
        output load_en, valid, bubble, flush, stall_cycles
    );

    // Datapath side.
    modport master (
        output stall_if, stall_mem, if_valid,
        output id_uses_sr1, id_uses_sr2, id_sr1, id_sr2, id_writes, id_dest,
        output ex_writes, ex_dest, wb_writes, wb_dest, br_taken,
        input  load_en, valid, bubble, flush, stall_cycles
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Per-register pending-write counters and the RAW compare against the
// instruction in ID. One increment (issue) and two decrements (retire,
// squash undo) may hit the same register in one cycle; the net is applied.
module reg_scoreboard #(
    parameter int NUM_STAGES = 5,
    parameter int NUM_REGS   = 8,
    localparam int REG_W     = $clog2(NUM_REGS),
    localparam int PW        = $clog2(NUM_STAGES) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_en,
    input  logic [REG_W-1:0] inc_reg,
    input  logic             dec0_en,
    input  logic [REG_W-1:0] dec0_reg,
    input  logic             dec1_en,
    input  logic [REG_W-1:0] dec1_reg,
    input  logic             uses_sr1,
    input  logic [REG_W-1:0] sr1,
    input  logic             uses_sr2,
    input  logic [REG_W-1:0] sr2,
    output logic             raw
);

    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] TWO      = PW'(2);
    localparam logic [PW-1:0] PEND_MAX = '1;

    logic [PW-1:0]       pend     [NUM_REGS];
    logic [PW-1:0]       pend_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] up, dn0, dn1;
    logic                underflow;

    // Decode which registers are touched by each update port.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            up[i]  = inc_en  && (inc_reg  == REG_W'(i));
            dn0[i] = dec0_en && (dec0_reg == REG_W'(i));
            dn1[i] = dec1_en && (dec1_reg == REG_W'(i));
        end
    end

    // Net update per register; saturate rather than wrap on either side.
    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            pend_nxt[i] = pend[i];
            case ({up[i], dn0[i], dn1[i]})
                3'b100: if (pend[i] != PEND_MAX) pend_nxt[i] = pend[i] + ONE;
                3'b010, 3'b001, 3'b111: begin
                    if (pend[i] == '0) underflow = 1'b1;
                    else               pend_nxt[i] = pend[i] - ONE;
                end
                3'b011: begin
                    if (pend[i] < TWO) begin
                        underflow   = 1'b1;
                        pend_nxt[i] = '0;
                    end else begin
                        pend_nxt[i] = pend[i] - TWO;
                    end
                end
                default: ;  // no change, or one up cancelling one down
            endcase
        end
    end

    // Counter storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) pend[i] <= pend_nxt[i];
        end
    end

    assign raw = (uses_sr1 && (pend[sr1] != '0)) || (uses_sr2 && (pend[sr2] != '0));

    // A retire or undo against an idle register means the datapath lost track.
    a_no_underflow: assert property (@(posedge clk) disable iff (reset) !underflow);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: global stall, RAW bubble, branch flush,
// per-register load enables and valid bits, and a stall cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int NP = NUM_STAGES - 1;

    logic             g, h, f, raw;
    logic             issue, retire, undo;
    logic [NP-1:0]    valid_q, valid_nxt;
    logic [CNT_W-1:0] stall_q;
    adv_mode_e        mode;

    assign g = hz.stall_if | hz.stall_mem;
    assign h = valid_q[0] & raw;
    assign f = ~g & valid_q[NP-2] & hz.br_taken;

    // Stall beats flush beats bubble.
    always_comb begin
        mode = ADV_NORMAL;
        if (g)      mode = ADV_HOLD;
        else if (f) mode = ADV_FLUSH;
        else if (h) mode = ADV_BUBBLE;
    end

    assign issue  = (mode == ADV_NORMAL) & valid_q[0];
    assign retire = ~g & valid_q[NP-1] & hz.wb_writes;
    // The ID/EX instruction is squashed by a flush; give back its pending slot.
    // Its slot still advances with its valid bit, the datapath kills its write.
    assign undo   = f & valid_q[1] & hz.ex_writes;

    // Zero-latency load enables, flags and next valid vector.
    always_comb begin
        hz.load_en = '1;
        hz.bubble  = 1'b0;
        hz.flush   = 1'b0;
        valid_nxt  = valid_q;
        case (mode)
            ADV_HOLD:   hz.load_en = '0;
            ADV_BUBBLE: begin
                hz.load_en[0] = 1'b0;
                hz.bubble     = 1'b1;
                valid_nxt     = {valid_q[NP-2:1], 1'b0, valid_q[0]};
            end
            ADV_FLUSH: begin
                hz.flush  = 1'b1;
                valid_nxt = {valid_q[NP-2:1], 2'b00};
            end
            default: valid_nxt = {valid_q[NP-2:0], hz.if_valid};
        endcase
    end

    // Valid bits and stall counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            stall_q <= '0;
        end else begin
            valid_q <= valid_nxt;
            if (g | h) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign hz.valid        = valid_q;
    assign hz.stall_cycles = stall_q;

    reg_scoreboard #(
        .NUM_STAGES (NUM_STAGES),
        .NUM_REGS   (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .inc_en   (issue & hz.id_writes),
        .inc_reg  (hz.id_dest),
        .dec0_en  (retire),
        .dec0_reg (hz.wb_dest),
        .dec1_en  (undo),
        .dec1_reg (hz.ex_dest),
        .uses_sr1 (hz.id_uses_sr1),
        .sr1      (hz.id_sr1),
        .uses_sr2 (hz.id_uses_sr2),
        .sr2      (hz.id_sr2),
        .raw      (raw)
    );

endmodule
